instr_fetch_decode: RTL and testbench

- Front end of the picoMIPS core; the reading/decoding counterpart of the instruction encoding `{opcode, reg1, reg2, branch}` written into program memory.
- Owns the program counter and drives the synchronous-read program memory address.
- Splits each returned word into registered opcode/reg1/reg2/branch fields with a valid flag toward execute.
- Supports downstream stall and execute-driven branch redirect with a one-bubble flush.

---
 rtl/instr_fetch_decode.sv | 117 +++++++++++
 tb/tb_instr_fetch_decode.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_decode.sv
`default_nettype none
// =============================================================================
// instr_fetch_decode : picoMIPS front end - PC, program-memory fetch, decode
// Revision 1.0
// =============================================================================
module instr_fetch_decode #(
  parameter int REG_ADDR_W  = 3,
  parameter int PROG_ADDR_W = 5,
  parameter int INSTR_W     = 1 + 2 * REG_ADDR_W + PROG_ADDR_W
) (
  input  logic                   clk,
  input  logic                   n_reset,
  output logic [PROG_ADDR_W-1:0] mem_addr,
  input  logic [INSTR_W-1:0]     mem_data,
  input  logic                   stall,
  input  logic                   branch_taken,
  output logic                   valid,
  output logic                   opcode,
  output logic [REG_ADDR_W-1:0]  reg1,
  output logic [REG_ADDR_W-1:0]  reg2,
  output logic [PROG_ADDR_W-1:0] branch_addr,
  output logic [PROG_ADDR_W-1:0] pc_out
);

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [PROG_ADDR_W-1:0] fetch_pc_q;
  logic                   valid_q, valid_d;
  logic                   opcode_q, opcode_d;
  logic [REG_ADDR_W-1:0]  reg1_q, reg1_d;
  logic [REG_ADDR_W-1:0]  reg2_q, reg2_d;
  logic [PROG_ADDR_W-1:0] branch_q, branch_d;
  logic [PROG_ADDR_W-1:0] pc_out_q, pc_out_d;
  logic                   redirect;

  // valid_q is only ever set in RUN, so a redirect cannot fire during BOOT.
  assign redirect = branch_taken && valid_q;

  always_comb begin
    mem_addr = fetch_pc_q + 1'b1;
    if (!n_reset) begin
      mem_addr = '0;
    end else if (state_q == ST_BOOT) begin
      mem_addr = '0;
    end else if (redirect) begin
      mem_addr = branch_q;
    end else if (stall) begin
      mem_addr = fetch_pc_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    opcode_d = opcode_q;
    reg1_d   = reg1_q;
    reg2_d   = reg2_q;
    branch_d = branch_q;
    pc_out_d = pc_out_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect) begin
          // Wrong-path word on mem_data is dropped; target arrives next cycle.
          valid_d = 1'b0;
        end else if (!stall) begin
          valid_d  = 1'b1;
          opcode_d = mem_data[INSTR_W-1];
          reg1_d   = mem_data[INSTR_W-2 -: REG_ADDR_W];
          reg2_d   = mem_data[INSTR_W-2-REG_ADDR_W -: REG_ADDR_W];
          branch_d = mem_data[PROG_ADDR_W-1:0];
          pc_out_d = fetch_pc_q;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= '0;
      valid_q    <= 1'b0;
      opcode_q   <= 1'b0;
      reg1_q     <= '0;
      reg2_q     <= '0;
      branch_q   <= '0;
      pc_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= mem_addr;
      valid_q    <= valid_d;
      opcode_q   <= opcode_d;
      reg1_q     <= reg1_d;
      reg2_q     <= reg2_d;
      branch_q   <= branch_d;
      pc_out_q   <= pc_out_d;
    end
  end

  assign valid       = valid_q;
  assign opcode      = opcode_q;
  assign reg1        = reg1_q;
  assign reg2        = reg2_q;
  assign branch_addr = branch_q;
  assign pc_out      = pc_out_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_decode.sv
`default_nettype none
// =============================================================================
// tb_instr_fetch_decode : random + directed check of instr_fetch_decode
// Revision 1.0
// =============================================================================
module tb_instr_fetch_decode;
  localparam int RW = 3;
  localparam int PW = 5;
  localparam int IW = 1 + 2 * RW + PW;
  localparam int DEPTH = 1 << PW;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic          stall = 1'b0;
  logic          branch_taken = 1'b0;
  logic [PW-1:0] mem_addr;
  logic [IW-1:0] mem_data;
  logic          valid, opcode;
  logic [RW-1:0] reg1, reg2;
  logic [PW-1:0] branch_addr, pc_out;

  logic [IW-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  // Synchronous-read program memory.
  always @(posedge clk) mem_data <= mem[mem_addr];

  instr_fetch_decode #(.REG_ADDR_W(RW), .PROG_ADDR_W(PW)) dut (
    .clk(clk), .n_reset(n_reset), .mem_addr(mem_addr), .mem_data(mem_data),
    .stall(stall), .branch_taken(branch_taken), .valid(valid), .opcode(opcode),
    .reg1(reg1), .reg2(reg2), .branch_addr(branch_addr), .pc_out(pc_out)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: which word is presented, and which address is in flight.
  bit m_known = 0, m_boot = 0, m_valid = 0, m_clr = 0;
  int m_fetch = 0, m_pc = 0, m_word = 0;
  logic [PW-1:0] last_addr;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int exp_addr(input bit rst_n, input bit st, input bit br);
    if (!rst_n) return 0;
    if (m_boot) return 0;
    if (br && m_valid) return m_word % DEPTH;
    if (st) return m_fetch;
    return (m_fetch + 1) % DEPTH;
  endfunction

  task automatic cycle(input bit rst_n, input bit st, input bit br);
    int ea;
    bit n_known, n_boot, n_valid, n_clr;
    int n_fetch, n_pc, n_word;
    @(negedge clk);
    n_reset = rst_n; stall = st; branch_taken = br;
    #1;
    ea = exp_addr(rst_n, st, br);
    last_addr = mem_addr;
    if (m_known || !rst_n) chk("mem_addr", 32'(mem_addr), 32'(ea));
    if (m_known) begin
      chk("valid", 32'(valid), 32'(m_valid));
      if (m_valid || m_clr) begin
        chk("opcode", 32'(opcode), 32'((m_word >> (IW - 1)) & 1));
        chk("reg1", 32'(reg1), 32'((m_word >> (IW - 1 - RW)) % (1 << RW)));
        chk("reg2", 32'(reg2), 32'((m_word >> PW) % (1 << RW)));
        chk("branch_addr", 32'(branch_addr), 32'(m_word % DEPTH));
        chk("pc_out", 32'(pc_out), 32'(m_pc));
      end
    end
    n_known = m_known; n_boot = m_boot; n_valid = m_valid; n_clr = m_clr;
    n_fetch = m_fetch; n_pc = m_pc; n_word = m_word;
    if (!rst_n) begin
      n_known = 1; n_boot = 1; n_fetch = 0; n_valid = 0;
      n_pc = 0; n_word = 0; n_clr = 1;
    end else if (m_known) begin
      if (m_boot) begin
        n_boot = 0;
      end else if (br && m_valid) begin
        n_valid = 0;
      end else if (!st) begin
        n_valid = 1; n_pc = m_fetch; n_word = int'(mem[m_fetch]); n_clr = 0;
      end
      n_fetch = ea;
    end
    @(posedge clk);
    m_known = n_known; m_boot = n_boot; m_valid = n_valid; m_clr = n_clr;
    m_fetch = n_fetch; m_pc = n_pc; m_word = n_word;
    #2;
  endtask

  task automatic lit_fields(input string tag, input int op, input int r1, input int r2,
                            input int br, input int pc);
    chk({tag, "_opcode"}, 32'(opcode), 32'(op));
    chk({tag, "_reg1"}, 32'(reg1), 32'(r1));
    chk({tag, "_reg2"}, 32'(reg2), 32'(r2));
    chk({tag, "_branch"}, 32'(branch_addr), 32'(br));
    chk({tag, "_pc"}, 32'(pc_out), 32'(pc));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = IW'($urandom);
    mem[0] = 12'hAA7;
    mem[1] = 12'h123;
    mem[2] = 12'h5C7;  // branch field 7
    mem[8] = 12'h3C2;  // branch field 2

    cycle(0, 0, 0);
    cycle(0, 0, 0);
    // BOOT cycle with a branch request that must be ignored.
    cycle(1, 0, 1);
    chk("boot_addr", 32'(last_addr), 0);
    chk("boot_valid", 32'(valid), 0);
    cycle(1, 0, 0);
    chk("first_valid", 32'(valid), 1);
    chk("first_addr", 32'(last_addr), 1);
    lit_fields("instr0", 1, 2, 5, 7, 0);
    cycle(1, 0, 0);
    lit_fields("instr1", 0, 1, 1, 3, 1);
    cycle(1, 0, 0);
    chk("pc2", 32'(pc_out), 2);
    cycle(1, 0, 1);
    chk("br_addr", 32'(last_addr), 7);
    chk("br_bubble", 32'(valid), 0);
    cycle(1, 0, 0);
    chk("br_target_pc", 32'(pc_out), 7);
    chk("br_target_valid", 32'(valid), 1);
    cycle(1, 0, 0);
    cycle(1, 1, 1);
    chk("brst_addr", 32'(last_addr), 2);
    chk("brst_bubble", 32'(valid), 0);
    cycle(1, 0, 0);
    chk("brst_pc", 32'(pc_out), 2);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("pre_stall_pc", 32'(pc_out), 4);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 0);
      chk("stall_addr", 32'(last_addr), 5);
      chk("stall_pc", 32'(pc_out), 4);
    end
    cycle(1, 0, 0);
    chk("post_stall_pc5", 32'(pc_out), 5);
    cycle(1, 0, 0);
    chk("post_stall_pc6", 32'(pc_out), 6);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 1, 0);
    chk("pc9", 32'(pc_out), 9);
    cycle(0, 1, 0);
    chk("midrst_addr", 32'(last_addr), 0);
    chk("midrst_valid", 32'(valid), 0);
    lit_fields("midrst", 0, 0, 0, 0, 0);

    // Free run across the address wrap.
    for (int i = 1; i <= 35; i++) begin
      cycle(1, 0, 0);
      if (i == 33) begin
        chk("wrap_pc31", 32'(pc_out), 31);
        chk("wrap_valid31", 32'(valid), 1);
      end
      if (i == 34) begin
        chk("wrap_pc0", 32'(pc_out), 0);
        chk("wrap_valid0", 32'(valid), 1);
      end
    end

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) >= 2, $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
